// File: rtl/mul_unit.sv
// mul_unit: iterative radix-2 shift-add multiplier for RV32M MUL/MULH/MULHSU/MULHU.
// Operands are magnitude-converted on start. One add/shift is done per cycle for n
// cycles, then a FIX cycle applies the sign and selects the half. done pulses for one
// cycle and result holds until the next completion.
// Optional: define MUL_ZERO_SKIP_EN to finish in one FIX cycle when either operand is zero.
// Ports:
//   clk    - clock, rising edge
//   rst    - synchronous active-high reset
//   start  - request, sampled only in IDLE
//   op     - 00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
//   rs1    - multiplicand
//   rs2    - multiplier
//   busy   - high in CALC/FIX
//   done   - one-cycle completion pulse
//   result - registered selected half of the product
module mul_unit #(
  parameter int n  = 32,
  parameter int CW = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic [n-1:0] rs1,
  input  logic [n-1:0] rs2,
  output logic         busy,
  output logic         done,
  output logic [n-1:0] result
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t         state, state_nx;
  logic [1:0]     op_q;
  logic [n:0]     mcand, mplier;
  logic           neg;
  logic [2*n-1:0] acc;
  logic [CW-1:0]  cnt;

  logic           a_sgn, b_sgn, zero_op;
  logic [n:0]     a_ext, b_ext, a_mag, b_mag;
  logic [n:0]     sum;
  logic [2*n:0]   shifted;
  logic [2*n-1:0] prod_fix;

  // Sign extension to n+1 bits keeps |0x80000000| = 2^31 representable.
  always_comb begin
    a_sgn = ((op == 2'b01) || (op == 2'b10)) && rs1[n-1];
    b_sgn = (op == 2'b01) && rs2[n-1];
    a_ext = {a_sgn, rs1};
    b_ext = {b_sgn, rs2};
    a_mag = a_sgn ? -a_ext : a_ext;
    b_mag = b_sgn ? -b_ext : b_ext;
`ifdef MUL_ZERO_SKIP_EN
    zero_op = (rs1 == '0) || (rs2 == '0);
`else
    zero_op = 1'b0;
`endif
  end

  // Add into the upper half with a carry bit, then shift the whole accumulator right.
  always_comb begin
    sum      = {1'b0, acc[2*n-1:n]} + (mplier[0] ? mcand : '0);
    shifted  = {sum, acc[n-1:0]};
    prod_fix = neg ? -acc : acc;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = zero_op ? FIX : CALC;
      CALC:    if (cnt == CW'(n - 1)) state_nx = FIX;
      FIX:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      op_q   <= '0;
      mcand  <= '0;
      mplier <= '0;
      neg    <= 1'b0;
      acc    <= '0;
      cnt    <= '0;
      done   <= 1'b0;
      result <= '0;
    end else begin
      state <= state_nx;
      done  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            op_q   <= op;
            mcand  <= a_mag;
            mplier <= b_mag;
            neg    <= a_sgn ^ b_sgn;
            acc    <= '0;
            cnt    <= '0;
          end
        end
        CALC: begin
          acc    <= shifted[2*n:1];
          mplier <= mplier >> 1;
          cnt    <= cnt + CW'(1);
        end
        FIX: begin
          done   <= 1'b1;
          result <= (op_q == 2'b00) ? prod_fix[n-1:0] : prod_fix[2*n-1:n];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_unit.sv
module tb_mul_unit;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [1:0]  op;
  logic [31:0] rs1, rs2;
  logic        busy, done;
  logic [31:0] result;

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] res;
    int unsigned due;
  } exp_t;
  exp_t exp_q[$];

`ifdef MUL_ZERO_SKIP_EN
  localparam int unsigned ZLAT = 1;
`else
  localparam int unsigned ZLAT = 33;
`endif

  mul_unit #(.n(32), .CW(6)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op),
    .rs1(rs1), .rs2(rs2), .busy(busy), .done(done), .result(result)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=0x%08h required=0x%08h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: pops one expectation per done pulse.
  logic prev_done = 1'b0;
  always @(negedge clk) begin : monitor
    exp_t e;
    if (done === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done actual=done_high required=no_done (cycle %0d)", cyc);
      end else begin
        e = exp_q.pop_front();
        chk("result", result, e.res);
        chk("latency_cycle", cyc, e.due);
        chk("busy_at_done", 32'(busy), 32'd0);
      end
      chk("done_width", 32'(prev_done), 32'd0);
    end
    prev_done = done;
  end

  // Called at a negedge; returns at the negedge after the start edge.
  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_res, input int unsigned lat, input bit track,
                       output int unsigned due);
    op = o; rs1 = a; rs2 = b; start = 1'b1;
    due = cyc + 1 + lat;
    if (track) exp_q.push_back('{exp_res, due});
    @(negedge clk);
    start = 1'b0;
    op = ~o; rs1 = ~a; rs2 = ~b;
  endtask

  task automatic wait_until(input int unsigned target);
    int unsigned guard = 0;
    while (cyc < target && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    chk("wait_reached", cyc, target);
  endtask

  task automatic drain();
    int unsigned guard = 0;
    while (exp_q.size() != 0 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    chk("drain_empty", exp_q.size(), 32'd0);
    @(negedge clk);
  endtask

  initial begin
    int unsigned d, d1;
    rst = 1'b1; start = 1'b0; op = 2'b00; rs1 = '0; rs2 = '0;
    repeat (3) @(negedge clk);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_result", result, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // MUL 7 x -3
    issue(2'b00, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, 1'b1, d);
    chk("busy_in_calc", 32'(busy), 32'd1);
    drain();

    // Reset in the middle of MULHU
    issue(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 33, 1'b0, d);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midreset_busy", 32'(busy), 32'd0);
    chk("midreset_done", 32'(done), 32'd0);
    chk("midreset_result", result, 32'd0);
    repeat (40) @(negedge clk);
    issue(2'b00, 32'd3, 32'd5, 32'h0000_000F, 33, 1'b1, d);
    drain();

    // MULH / MUL most-negative squared
    issue(2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33, 1'b1, d);
    drain();
    issue(2'b00, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 33, 1'b1, d);
    drain();

    // MULHSU / MULHU all ones
    issue(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 1'b1, d);
    drain();
    issue(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, 1'b1, d);
    drain();

    // Start while busy is ignored; back-to-back issue in the done cycle
    issue(2'b00, 32'd2, 32'd2, 32'd4, 33, 1'b1, d);
    repeat (4) @(negedge clk);
    op = 2'b00; rs1 = 32'd9; rs2 = 32'd9; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_until(d);
    chk("b2b_done_cycle", 32'(done), 32'd1);
    issue(2'b00, 32'd9, 32'd9, 32'h0000_0051, 33, 1'b1, d1);
    drain();

    // Zero operand, latency depends on build option
    issue(2'b00, 32'd0, 32'h0000_1234, 32'd0, ZLAT, 1'b1, d);
    drain();
    repeat (5) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mul_unit.md
Name: mul_unit

Overview:
- Iterative radix-2 shift-add multiplier for the RV32M MUL/MULH/MULHSU/MULHU instructions.
- Sits in the execute stage and drives the writeback mux's multiplication-result input (select 3'b100).
- Operands are accepted on a start pulse; a one-cycle done pulse is produced after a fixed latency.
- The result is held stable until the next accepted start, so writeback can sample it at any later cycle.

Parameters:
- n, 32, operand/result width; the product register is 2n bits.
- CW, 6, iteration-counter width; must satisfy 2^CW > n.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- op  input  2  00 MUL (low n bits), 01 MULH (s×s high), 10 MULHSU (s×u high), 11 MULHU (u×u high).
- rs1  input  n  multiplicand.
- rs2  input  n  multiplier.
- busy  output  1  high while a multiply is in flight (CALC or FIX).
- done  output  1  one-cycle pulse when result is updated.
- result  output  n  selected half of the product; registered and held.

Behaviour:
- Reset (synchronous, active-high; rst sampled high at an edge):
  - state=IDLE, busy=0, done=0, result=0, counter=0, internal product=0.
  - Applies mid-operation: the in-flight multiply is discarded and no done pulse is produced.
- States: IDLE, CALC, FIX.
- IDLE:
  - done is 0 except on the single cycle after FIX.
  - When start=1, latch op, |rs1|, |rs2| and neg = sign(rs1)^sign(rs2) per the signedness rules below.
  - Then clear the product, set counter=0, busy=1, and go to CALC.
  - When start=0, remain in IDLE.
- Signedness:
  - MUL/MULHU: both operands unsigned (MUL's low half is sign-agnostic); neg=0.
  - MULH: both operands signed.
  - MULHSU: rs1 signed, rs2 unsigned.
  - Magnitude of the most-negative value (0x80000000) is 2^31; hold it in n+1-bit magnitude registers, no overflow.
- CALC, one iteration per cycle:
  - If multiplier bit[0]=1, add the multiplicand to the upper half of the accumulator.
  - Shift the accumulator/multiplier right by 1.
  - Counter increments by 1 per iteration.
  - After the iteration with counter=n-1, go to FIX.
  - Exactly n CALC cycles.
- FIX:
  - If neg=1, two's-complement negate the 2n-bit product.
  - result = low n bits for MUL, high n bits otherwise.
  - done=1 for this one cycle only; busy=0; return to IDLE.
- Latency: start sampled at edge E0 → done and result visible after edge E0+n+1 (33 cycles for n=32).
- Throughput: a new start is accepted in the cycle done is high (state is already IDLE), giving back-to-back operation with no bubble.
- start while busy=1: ignored; operands are not re-latched and no error is flagged.
- op/rs1/rs2 changes after the start edge have no effect on the in-flight operation.
- result changes only on the done edge; otherwise it holds its value, including across idle periods.

Optional Feature:
- Macro: MUL_ZERO_SKIP_EN.
- Defined:
  - In IDLE, if start=1 and either operand is zero, skip CALC.
  - Go directly to FIX with a zero product; done is visible after E0+1.
  - busy is high for that one cycle.
- Undefined:
  - All operations take the fixed n+1 latency.
  - The zero-detect logic is absent.

Test Plan:
- Reset mid-op:
  - Stimulus: start MULHU 0xFFFFFFFF×0xFFFFFFFF, assert rst at cycle 10.
  - Required: busy=0, done=0, result=0 on the next cycle, no later done pulse.
  - After that, a fresh MUL 3×5 gives result=0x0000000F.
- MUL 7×(-3) (rs2=0xFFFFFFFD):
  - done exactly 33 cycles after start.
  - result=0xFFFFFFEB.
- MULH 0x80000000×0x80000000:
  - result=0x40000000.
  - MUL on the same operands gives 0x00000000.
- MULHSU rs1=0xFFFFFFFF (−1), rs2=0xFFFFFFFF (2^32−1):
  - result=0xFFFFFFFF.
  - MULHU on the same operands gives 0xFFFFFFFE.
- Start during busy:
  - Stimulus: start MUL 2×2, pulse start with 9×9 at cycle 5, then issue 9×9 in the done cycle.
  - Required: first result=4 with a single done pulse.
  - Second done 33 cycles later with result=0x51.
- MUL_ZERO_SKIP_EN:
  - Defined: MUL 0×0x1234 gives done after 1 cycle, result=0.
  - Undefined: the same operation gives done after 33 cycles, result=0.
